// File: rtl/wb_tg_pkg.sv
// Shared types and constants for the Wishbone traffic master.
// Also intended for reuse by the HVL-side scoreboard.
package wb_tg_pkg;

    typedef enum logic [1:0] {
        OP_WRITE,
        OP_READ,
        OP_WR_RD,
        OP_RSVD
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        TURN,
        READ,
        DONE
    } state_e;

    localparam logic [31:0] PAT_STEP_DEFAULT = 32'h9E3779B9;

endpackage

// File: rtl/wb_traffic_master_if.sv
// Command handshake plus Wishbone classic bus between the
// traffic master and its environment.
interface wb_traffic_master_if #(
    parameter int AW = 26,
    parameter int DW = 32
);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [AW-1:0]   cmd_addr;
    logic [7:0]      cmd_len;
    logic [DW-1:0]   cmd_seed;

    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_ack_i;
    logic [DW-1:0]   wb_dat_i;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr,
        input  cmd_len, cmd_seed,
        output cmd_ready,
        output wb_cyc_o, wb_stb_o, wb_we_o,
        output wb_addr_o, wb_dat_o, wb_sel_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr,
        output cmd_len, cmd_seed,
        input  cmd_ready,
        input  wb_cyc_o, wb_stb_o, wb_we_o,
        input  wb_addr_o, wb_dat_o, wb_sel_o,
        output wb_ack_i, wb_dat_i
    );

endinterface

// File: rtl/wb_tg_pattern.sv
// Additive data-pattern generator: seed, seed+STEP, seed+2*STEP...
// Load has priority over advance.
module wb_tg_pattern
    import wb_tg_pkg::*;
#(
    parameter int            DW   = 32,
    parameter logic [DW-1:0] STEP = DW'(PAT_STEP_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] seed,
    input  logic          advance,
    output logic [DW-1:0] pattern
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= '0;
        end else if (load) begin
            pattern <= seed;
        end else if (advance) begin
            pattern <= pattern + STEP;
        end
    end

endmodule

// File: rtl/wb_traffic_master.sv
// Wishbone classic burst master: write, read or write-then-readback
// of a generated pattern, with read compare and per-beat timeout.
module wb_traffic_master
    import wb_tg_pkg::*;
#(
    parameter int            AW       = 26,
    parameter int            DW       = 32,
    parameter int            TIMEOUT  = 1024,
    parameter logic [DW-1:0] PAT_STEP = DW'(PAT_STEP_DEFAULT)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 sdr_init_done,
    wb_traffic_master_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          err_cnt,
    output logic                 timeout
);

    localparam int            TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

    state_e        state;
    state_e        state_nx;
    op_e           op_q;
    logic [AW-1:0] base_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    len_q;
    logic [7:0]    beat_q;
    logic [DW-1:0] seed_q;
    logic [DW-1:0] pat;
    logic [TW-1:0] to_cnt;

    logic          accept;
    logic          active;
    logic          ack;
    logic          last;
    logic          expired;
    logic          pat_load;
    logic [DW-1:0] pat_seed;

    assign accept   = bus.cmd_valid && bus.cmd_ready;
    assign active   = (state == WRITE) || (state == READ);
    assign ack      = active && bus.wb_ack_i;
    // len_q of 0 wraps to 255 here, giving a 256-beat burst
    assign last     = (beat_q == len_q - 8'd1);
    assign expired  = active && !bus.wb_ack_i && (to_cnt == TO_MAX);
    assign pat_load = accept || (state == TURN);
    assign pat_seed = accept ? bus.cmd_seed : seed_q;

    wb_tg_pattern #(
        .DW   (DW),
        .STEP (PAT_STEP)
    ) u_pat (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .load    (pat_load),
        .seed    (pat_seed),
        .advance (ack),
        .pattern (pat)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.cmd_ready = 1'b0;
        bus.wb_cyc_o  = active;
        bus.wb_stb_o  = active;
        bus.wb_we_o   = (state == WRITE);
        bus.wb_sel_o  = {(DW/8){active}};
        bus.wb_addr_o = addr_q;
        bus.wb_dat_o  = pat;
        busy          = (state != IDLE);
        done          = (state == DONE);
        unique case (state)
            IDLE: begin
                bus.cmd_ready = sdr_init_done && !wb_rst_i;
                if (accept) begin
                    if (bus.cmd_op == OP_READ) state_nx = READ;
                    else                       state_nx = WRITE;
                end
            end
            WRITE: begin
                if (ack && last) begin
                    if (op_q == OP_WRITE) state_nx = DONE;
                    else                  state_nx = TURN;
                end else if (expired) begin
                    state_nx = DONE;
                end
            end
            TURN: state_nx = READ;
            READ: begin
                if ((ack && last) || expired) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            op_q    <= OP_WRITE;
            base_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            seed_q  <= '0;
            to_cnt  <= '0;
            err_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op_e'(bus.cmd_op);
                base_q  <= bus.cmd_addr & ~AW'(3);
                addr_q  <= bus.cmd_addr & ~AW'(3);
                len_q   <= bus.cmd_len;
                beat_q  <= '0;
                seed_q  <= bus.cmd_seed;
                err_cnt <= '0;
                timeout <= 1'b0;
            end else if (state == TURN) begin
                addr_q <= base_q;
                beat_q <= '0;
            end else if (ack) begin
                addr_q <= addr_q + AW'(4);
                beat_q <= beat_q + 8'd1;
            end
            // counter idles at zero outside bus phases, so entry clears it
            if (!active || ack) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (expired) begin
                timeout <= 1'b1;
            end
            if (ack && (state == READ) && (bus.wb_dat_i != pat)
                && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_traffic_master.sv
// Bench for wb_traffic_master: beat-level expectation queue plus
// directed commands with hand-computed literals.
module tb_wb_traffic_master;

    localparam int          AW      = 26;
    localparam int          DW      = 32;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] STEP    = 32'h9E3779B9;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done = 1'b0;
    logic          ack_en = 1'b1;
    logic          ack_force = 1'b0;
    logic          corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [15:0]   err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int stb_cycles = 0;
    int w;

    beat_t         exp_q[$];
    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_dat[$];
    bit            cyc_log[$];
    logic [31:0]   mem [0:1023];

    wb_traffic_master_if #(.AW(AW), .DW(DW)) bus ();

    wb_traffic_master #(
        .AW       (AW),
        .DW       (DW),
        .TIMEOUT  (TIMEOUT),
        .PAT_STEP (STEP)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .sdr_init_done (init_done),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .err_cnt       (err_cnt),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    assign bus.wb_ack_i = (bus.wb_stb_o & ack_en) | ack_force;
    assign bus.wb_dat_i = mem[bus.wb_addr_o[11:2]]
        ^ ((corrupt_en && bus.wb_addr_o == corrupt_addr)
           ? 32'h0000_0100 : 32'h0);

    always @(posedge clk) begin
        if (bus.wb_stb_o && bus.wb_ack_i && bus.wb_we_o)
            mem[bus.wb_addr_o[11:2]] <= bus.wb_dat_o;
    end

    task automatic cmp(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Expected beats straight from the closed-form pattern/address rules
    task automatic push_cmd(input logic [1:0]    op,
                            input logic [AW-1:0] addr,
                            input logic [7:0]    len,
                            input logic [31:0]   seed);
        int n;
        logic [AW-1:0] base;
        beat_t b;
        n = (len == 8'd0) ? 256 : int'(len);
        base = {addr[AW-1:2], 2'b00};
        for (int ph = 0; ph < 2; ph++) begin
            if (!(ph == 0 && op == 2'd1) && !(ph == 1 && op == 2'd0)) begin
                for (int k = 0; k < n; k++) begin
                    b.we   = (ph == 0);
                    b.addr = base + AW'(4 * k);
                    b.data = seed + 32'(k) * STEP;
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    function automatic logic [31:0] pack_cyc();
        logic [31:0] v;
        v = '0;
        foreach (cyc_log[i]) v = {v[30:0], cyc_log[i]};
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            cmp("cyc_eq_stb", bus.wb_cyc_o, bus.wb_stb_o);
            cmp("sel", bus.wb_sel_o, bus.wb_stb_o ? 4'hF : 4'h0);
            if (busy) cyc_log.push_back(bus.wb_cyc_o);
            if (bus.wb_stb_o) begin
                stb_cycles++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_beat: got stb at %0h, want none",
                             bus.wb_addr_o);
                end else begin
                    cmp("beat_we", bus.wb_we_o, exp_q[0].we);
                    cmp("beat_addr", bus.wb_addr_o, exp_q[0].addr);
                    if (exp_q[0].we)
                        cmp("beat_wdata", bus.wb_dat_o, exp_q[0].data);
                    if (bus.wb_ack_i) begin
                        log_addr.push_back(bus.wb_addr_o);
                        log_dat.push_back(bus.wb_dat_o);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic run_cmd(input logic [1:0]    op,
                           input logic [AW-1:0] addr,
                           input logic [7:0]    len,
                           input logic [31:0]   seed,
                           input bit            wait_done,
                           input logic [15:0]   exp_err,
                           input logic          exp_to,
                           output int           waited);
        int n;
        push_cmd(op, addr, len, seed);
        log_addr.delete();
        log_dat.delete();
        cyc_log.delete();
        stb_cycles = 0;
        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_seed  = seed;
        bus.cmd_valid = 1'b1;
        waited = 0;
        while (!bus.cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept: got no cmd_ready, want ready");
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        cmp("first_stb", bus.wb_stb_o, 1'b1);
        cmp("busy_after_accept", busy, 1'b1);
        cmp("timeout_cleared", timeout, 1'b0);
        cmp("err_cleared", err_cnt, 16'd0);
        if (wait_done) begin
            n = 0;
            while (!done && n < 3000) begin
                @(negedge clk);
                n++;
            end
            cmp("done_seen", done, 1'b1);
            cmp("busy_in_done", busy, 1'b1);
            cmp("err_cnt", err_cnt, exp_err);
            cmp("timeout", timeout, exp_to);
            if (exp_to) exp_q.delete();
            else cmp("beats_left", exp_q.size(), 0);
            @(negedge clk);
            cmp("done_pulse", done, 1'b0);
            cmp("busy_after", busy, 1'b0);
            cmp("err_hold", err_cnt, exp_err);
            cmp("timeout_hold", timeout, exp_to);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_seed  = '0;
        init_done     = 1'b1;
        repeat (3) @(negedge clk);
        cmp("rst_ready", bus.cmd_ready, 1'b0);
        cmp("rst_cyc", bus.wb_cyc_o, 1'b0);
        cmp("rst_stb", bus.wb_stb_o, 1'b0);
        cmp("rst_we", bus.wb_we_o, 1'b0);
        cmp("rst_addr", bus.wb_addr_o, 26'h0);
        cmp("rst_dat", bus.wb_dat_o, 32'h0);
        cmp("rst_sel", bus.wb_sel_o, 4'h0);
        cmp("rst_busy", busy, 1'b0);
        cmp("rst_done", done, 1'b0);
        cmp("rst_err", err_cnt, 16'h0);
        cmp("rst_timeout", timeout, 1'b0);

        init_done = 1'b0;
        rst = 1'b0;
        bus.cmd_valid = 1'b1;
        ack_force = 1'b1;
        repeat (4) begin
            @(negedge clk);
            cmp("gated_ready", bus.cmd_ready, 1'b0);
            cmp("gated_stb", bus.wb_stb_o, 1'b0);
            cmp("gated_busy", busy, 1'b0);
            cmp("gated_done", done, 1'b0);
        end
        bus.cmd_valid = 1'b0;
        ack_force = 1'b0;
        init_done = 1'b1;

        run_cmd(2'd0, 26'h100, 8'd4, 32'h0, 1'b1, 16'd0, 1'b0, w);
        cmp("accept_latency", w, 0);
        cmp("wr_stb_cycles", stb_cycles, 4);
        cmp("wr_cyc_trace", pack_cyc(), 32'h1E);
        cmp("wr_cyc_len", cyc_log.size(), 5);
        cmp("wr_d0", log_dat[0], 32'h00000000);
        cmp("wr_d1", log_dat[1], 32'h9E3779B9);
        cmp("wr_d2", log_dat[2], 32'h3C6EF372);
        cmp("wr_d3", log_dat[3], 32'hDAA66D2B);
        cmp("wr_a0", log_addr[0], 26'h100);
        cmp("wr_a3", log_addr[3], 26'h10C);

        run_cmd(2'd2, 26'h203, 8'd2, 32'h12345678, 1'b1, 16'd0, 1'b0, w);
        cmp("wrrd_stb_cycles", stb_cycles, 4);
        cmp("wrrd_cyc_trace", pack_cyc(), 32'h36);
        cmp("wrrd_cyc_len", cyc_log.size(), 6);
        cmp("wrrd_a0", log_addr[0], 26'h200);
        cmp("wrrd_ra1", log_addr[3], 26'h204);

        ack_en = 1'b0;
        run_cmd(2'd0, 26'h180, 8'd3, 32'hA5A5, 1'b1, 16'd0, 1'b1, w);
        cmp("to_stb_cycles", stb_cycles, 16);
        cmp("to_cyc_trace", pack_cyc(), 32'h1FFFE);
        cmp("to_cyc_len", cyc_log.size(), 17);
        cmp("to_no_beats", log_addr.size(), 0);
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
        cmp("to_idle", busy, 1'b0);

        corrupt_en = 1'b1;
        corrupt_addr = 26'h104;
        run_cmd(2'd1, 26'h100, 8'd3, 32'h0, 1'b1, 16'd1, 1'b0, w);
        cmp("rd_stb_cycles", stb_cycles, 3);
        corrupt_en = 1'b0;

        run_cmd(2'd0, 26'h3FFFFFC, 8'd0, 32'h1, 1'b1, 16'd0, 1'b0, w);
        cmp("wrap_stb_cycles", stb_cycles, 256);
        cmp("wrap_a1", log_addr[1], 26'h0000000);
        cmp("wrap_a255", log_addr[255], 26'h00003F8);
        cmp("wrap_beats", log_addr.size(), 256);

        run_cmd(2'd3, 26'h3FFFFFC, 8'd0, 32'h77, 1'b0, 16'd0, 1'b0, w);
        n = 0;
        while (!(bus.wb_stb_o && bus.wb_addr_o == 26'h24) && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmp("beat10_reached", bus.wb_addr_o, 26'h24);
        rst = 1'b1;
        @(negedge clk);
        cmp("mid_rst_cyc", bus.wb_cyc_o, 1'b0);
        cmp("mid_rst_stb", bus.wb_stb_o, 1'b0);
        cmp("mid_rst_busy", busy, 1'b0);
        cmp("mid_rst_ready", bus.cmd_ready, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        cmp("post_rst_ready", bus.cmd_ready, 1'b1);
        cmp("post_rst_cyc", bus.wb_cyc_o, 1'b0);
        cmp("rsvd_a1", log_addr[1], 26'h0000000);

        run_cmd(2'd0, 26'h300, 8'd1, 32'hCAFE, 1'b1, 16'd0, 1'b0, w);
        cmp("post_rst_stb_cycles", stb_cycles, 1);
        cmp("post_rst_d0", log_dat[0], 32'h0000CAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
